// File: rtl/key_switch_io_pkg.sv
// ---------------------------------------------------------------------------
// key_switch_io_pkg
//   Shared constants and helpers for the key/switch I/O responder.
//   - Register offsets (byte offsets from BASE, 16-bit word aligned)
//   - Read value returned when no register is selected
//   - Reset values of the KEY and SW paths
//   - Offset decoder used by the top-level address decoder
// ---------------------------------------------------------------------------
package key_switch_io_pkg;

    localparam logic [2:0]  KDATA_OFS = 3'd0;
    localparam logic [2:0]  SDATA_OFS = 3'd2;
    localparam logic [2:0]  KFLAG_OFS = 3'd4;
    localparam logic [2:0]  SFLAG_OFS = 3'd6;

    localparam logic [15:0] DOUT_MISS = 16'hDEAD;

    // Pushbuttons are active-low, so the idle (released) state is all ones.
    localparam logic [3:0]  KEY_RST   = 4'hF;
    localparam logic [9:0]  SW_RST    = 10'h0;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_KDATA,
        REG_SDATA,
        REG_KFLAG,
        REG_SFLAG
    } reg_e;

    // Maps the low three address bits onto a register; odd offsets hit nothing.
    function automatic reg_e decode_ofs(input logic [2:0] ofs);
        reg_e r;
        case (ofs)
            KDATA_OFS: r = REG_KDATA;
            SDATA_OFS: r = REG_SDATA;
            KFLAG_OFS: r = REG_KFLAG;
            SFLAG_OFS: r = REG_SFLAG;
            default:   r = REG_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_switch_io_debouncer.sv
// ---------------------------------------------------------------------------
// debouncer
//   Two-flop synchroniser followed by a per-bit consecutive-cycle debounce
//   counter. A debounced bit only follows its synchronised input after the
//   input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
//
// Ports
//   i_clk   system clock
//   i_rst   synchronous, active-high reset
//   i_raw   asynchronous raw inputs
//   o_deb   debounced value (registered)
//   o_chg   per-bit strobe: the matching o_deb bit flips at the next edge
// ---------------------------------------------------------------------------
module debouncer #(
    parameter int                 WIDTH           = 4,
    parameter logic [WIDTH-1:0]   RST_VAL         = '0,
    parameter int                 DEBOUNCE_CYCLES = 50000,
    parameter int                 CNTBITS         = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_deb,
    output logic [WIDTH-1:0] o_chg
);

    localparam logic [CNTBITS-1:0] LAST_CNT = CNTBITS'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [WIDTH-1:0]   r_deb;
    logic [CNTBITS-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0]   w_chg;

    // A bit flips when it still differs on the cycle its counter reaches the
    // terminal count, i.e. the difference has lasted DEBOUNCE_CYCLES cycles.
    always_comb begin
        w_chg = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_chg[i] = (r_sync2[i] != r_deb[i]) && (r_cnt[i] == LAST_CNT);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= RST_VAL;
            r_sync2 <= RST_VAL;
            r_deb   <= RST_VAL;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    // Any agreeing cycle breaks the run of differing cycles.
                    r_cnt[i] <= '0;
                end else if (w_chg[i]) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNTBITS'(1);
                end
            end
        end
    end

    assign o_deb = r_deb;
    assign o_chg = w_chg;

endmodule

// File: rtl/key_switch_io.sv
// ---------------------------------------------------------------------------
// key_switch_io
//   Memory-mapped responder for the pushbuttons and slide switches on the
//   processor's data-memory bus. Debounces KEY[3:0] and SW[9:0], records
//   sticky key-press / overrun / switch-change flags, and presents register
//   contents combinationally on DOUT whenever SEL is high.
//
//   Register map (byte offset from BASE):
//     +0 KDATA  {12'b0, debounced KEY}            read only
//     +2 SDATA  {6'b0, debounced SW}              read only
//     +4 KFLAG  [7:4] overrun, [3:0] press        write-1-to-clear
//     +6 SFLAG  [9:0] change                      write-1-to-clear
//
// Ports
//   CLK    system clock
//   RESET  synchronous, active-high reset
//   ADDR   byte address from the processor
//   DIN    write data
//   WE     write strobe (only acts when SEL is high)
//   SEL    high when ADDR hits one of the four registers
//   DOUT   read data for ADDR, DOUT_MISS when SEL is low
//   KEY    raw pushbuttons, active-low
//   SW     raw slide switches
// ---------------------------------------------------------------------------
module key_switch_io
    import key_switch_io_pkg::*;
#(
    parameter int               DBITS           = 16,
    parameter logic [DBITS-1:0] BASE            = 16'hFFF0,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               CNTBITS         = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [DBITS-1:0] ADDR,
    input  logic [DBITS-1:0] DIN,
    input  logic             WE,
    output logic             SEL,
    output logic [DBITS-1:0] DOUT,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW
);

    logic [3:0] w_key_deb;
    logic [3:0] w_key_chg;
    logic [9:0] w_sw_deb;
    logic [9:0] w_sw_chg;

    logic       w_base_hit;
    reg_e       w_reg;
    logic       w_wr_kflag;
    logic       w_wr_sflag;
    logic [3:0] w_key_press;
    logic [3:0] w_clr_press;
    logic [3:0] w_clr_ovr;
    logic [9:0] w_clr_sw;
    logic       w_unused_din;

    logic [3:0] r_kflag;
    logic [3:0] r_kovr;
    logic [9:0] r_sflag;

    debouncer #(
        .WIDTH           (4),
        .RST_VAL         (KEY_RST),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNTBITS         (CNTBITS)
    ) u_key_deb (
        .i_clk (CLK),
        .i_rst (RESET),
        .i_raw (KEY),
        .o_deb (w_key_deb),
        .o_chg (w_key_chg)
    );

    debouncer #(
        .WIDTH           (10),
        .RST_VAL         (SW_RST),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNTBITS         (CNTBITS)
    ) u_sw_deb (
        .i_clk (CLK),
        .i_rst (RESET),
        .i_raw (SW),
        .o_deb (w_sw_deb),
        .o_chg (w_sw_chg)
    );

    // Address decode: upper bits select the 8-byte window, the low three
    // bits pick a halfword register; odd byte addresses select nothing.
    assign w_base_hit = (ADDR[DBITS-1:3] == BASE[DBITS-1:3]);
    assign w_reg      = w_base_hit ? decode_ofs(ADDR[2:0]) : REG_NONE;
    assign SEL        = (w_reg != REG_NONE);

    assign w_wr_kflag = WE && (w_reg == REG_KFLAG);
    assign w_wr_sflag = WE && (w_reg == REG_SFLAG);

    assign w_clr_press = w_wr_kflag ? DIN[3:0] : 4'h0;
    assign w_clr_ovr   = w_wr_kflag ? DIN[7:4] : 4'h0;
    assign w_clr_sw    = w_wr_sflag ? DIN[9:0] : 10'h0;

    // A press is a debounced 1->0 transition: the bit is 1 now and flips.
    assign w_key_press = w_key_chg & w_key_deb;

    // Upper write-data bits carry no register content.
    assign w_unused_din = &{1'b0, DIN[DBITS-1:10]};

    // Flag registers. A new event ORs in after the clear mask, so a set on
    // the same edge as its W1C keeps the flag. Overrun needs the press flag
    // to survive the edge, so a simultaneous clear suppresses it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_kflag <= 4'h0;
            r_kovr  <= 4'h0;
            r_sflag <= 10'h0;
        end else begin
            r_kflag <= w_key_press | (r_kflag & ~w_clr_press);
            r_kovr  <= (w_key_press & r_kflag & ~w_clr_press) |
                       (r_kovr & ~w_clr_ovr);
            r_sflag <= w_sw_chg | (r_sflag & ~w_clr_sw);
        end
    end

    // Zero-latency read path.
    always_comb begin
        DOUT = DBITS'(DOUT_MISS);
        case (w_reg)
            REG_KDATA: DOUT = DBITS'(w_key_deb);
            REG_SDATA: DOUT = DBITS'(w_sw_deb);
            REG_KFLAG: DOUT = DBITS'({r_kovr, r_kflag});
            REG_SFLAG: DOUT = DBITS'(r_sflag);
            default:   DOUT = DBITS'(DOUT_MISS);
        endcase
    end

endmodule

// File: tb/tb_key_switch_io.sv
module tb_key_switch_io;

    localparam int          D    = 4;
    localparam logic [15:0] BASE = 16'hFFF0;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] ADDR = 16'h0;
    logic [15:0] DIN = 16'h0;
    logic        WE = 1'b0;
    logic        SEL;
    logic [15:0] DOUT;
    logic [3:0]  KEY = 4'hF;
    logic [9:0]  SW = 10'h0;

    key_switch_io #(
        .DBITS           (16),
        .BASE            (BASE),
        .DEBOUNCE_CYCLES (D),
        .CNTBITS         (16)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .ADDR  (ADDR),
        .DIN   (DIN),
        .WE    (WE),
        .SEL   (SEL),
        .DOUT  (DOUT),
        .KEY   (KEY),
        .SW    (SW)
    );

    always #5 CLK = ~CLK;

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        bit          sel_e;
        logic [15:0] dout_e;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // ---------------- reference model ----------------
    // Debounced bit flips once the last D synchronised samples all disagree
    // with it; the synchronised sample at an edge is the raw input taken two
    // edges earlier.
    bit         model_ok = 0;
    logic [3:0] m_key;
    logic [9:0] m_sw;
    logic [3:0] m_kflag, m_kovr;
    logic [9:0] m_sflag;
    logic [3:0] kraw[$];
    logic [9:0] sraw[$];
    logic [3:0] ksy[$];
    logic [9:0] ssy[$];

    function automatic void model_read(input logic [15:0] a, output bit s, output logic [15:0] d);
        s = (a >= BASE) && (a <= BASE + 16'd6) && (a % 2 == 0);
        d = 16'hDEAD;
        if (s) begin
            case (a - BASE)
                16'd0:   d = {12'b0, m_key};
                16'd2:   d = {6'b0, m_sw};
                16'd4:   d = {8'b0, m_kovr, m_kflag};
                default: d = {6'b0, m_sflag};
            endcase
        end
    endfunction

    task automatic model_edge(input bit rst, input logic [3:0] k, input logic [9:0] s,
                              input logic [15:0] a, input bit we, input logic [15:0] din);
        logic [3:0] nk;
        logic [9:0] ns;
        logic [3:0] press, clrp, clro;
        logic [9:0] chg, clrs;
        bit         all;
        if (rst) begin
            model_ok = 1;
            m_key = 4'hF; m_sw = 10'h0;
            m_kflag = 0; m_kovr = 0; m_sflag = 0;
            kraw = '{4'hF, 4'hF};
            sraw = '{10'h0, 10'h0};
            ksy.delete(); ssy.delete();
            return;
        end
        ksy.push_front(kraw[1]);
        ssy.push_front(sraw[1]);
        kraw.push_front(k); void'(kraw.pop_back());
        sraw.push_front(s); void'(sraw.pop_back());
        while (ksy.size() > D) void'(ksy.pop_back());
        while (ssy.size() > D) void'(ssy.pop_back());
        nk = m_key;
        ns = m_sw;
        for (int b = 0; b < 4; b++) begin
            all = (ksy.size() == D);
            for (int j = 0; j < ksy.size(); j++) if (ksy[j][b] == m_key[b]) all = 0;
            if (all) nk[b] = ~m_key[b];
        end
        for (int b = 0; b < 10; b++) begin
            all = (ssy.size() == D);
            for (int j = 0; j < ssy.size(); j++) if (ssy[j][b] == m_sw[b]) all = 0;
            if (all) ns[b] = ~m_sw[b];
        end
        press = m_key & ~nk;
        chg   = m_sw ^ ns;
        clrp  = (we && a == BASE + 16'd4) ? din[3:0] : 4'h0;
        clro  = (we && a == BASE + 16'd4) ? din[7:4] : 4'h0;
        clrs  = (we && a == BASE + 16'd6) ? din[9:0] : 10'h0;
        m_kovr  = (press & m_kflag & ~clrp) | (m_kovr & ~clro);
        m_kflag = press | (m_kflag & ~clrp);
        m_sflag = chg | (m_sflag & ~clrs);
        m_key = nk;
        m_sw  = ns;
    endtask

    // ---------------- driver ----------------
    logic [3:0] cur_key = 4'hF;
    logic [9:0] cur_sw  = 10'h0;

    task automatic step(input bit rst, input logic [15:0] a, input bit we, input logic [15:0] din,
                        input bit has_c, input string cname, input logic [15:0] cexp);
        exp_t e;
        bit   s;
        logic [15:0] d;
        RESET = rst; ADDR = a; WE = we; DIN = din; KEY = cur_key; SW = cur_sw;
        if (model_ok) begin
            model_read(a, s, d);
            e.name = "model"; e.sel_e = s; e.dout_e = d;
            sb.push_back(e);
        end
        if (has_c) begin
            e.name = cname; e.sel_e = (cexp != 16'hDEAD); e.dout_e = cexp;
            sb.push_back(e);
        end
        @(posedge CLK);
        model_edge(rst, cur_key, cur_sw, a, we, din);
        #1;
    endtask

    task automatic run(input int n, input logic [15:0] a);
        for (int i = 0; i < n; i++) step(0, a, 0, 16'h0, 0, "", 16'h0);
    endtask

    task automatic chk(input string name, input logic [15:0] a, input logic [15:0] exp);
        RESET = 0; ADDR = a; WE = 0; DIN = 16'h0;
        #1;
        n_checks++;
        if (SEL !== (exp != 16'hDEAD)) begin
            n_err++;
            $display("FAIL %s addr=%h: got SEL=%b", name, a, SEL);
        end
        n_checks++;
        if (DOUT !== exp) begin
            n_err++;
            $display("FAIL %s addr=%h: got DOUT=%h, want %h", name, a, DOUT, exp);
        end
        step(0, a, 0, 16'h0, 1, name, exp);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] din);
        step(0, a, 1, din, 0, "", 16'h0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (SEL !== e.sel_e || DOUT !== e.dout_e) begin
                    n_err++;
                    $display("FAIL %s addr=%h: got SEL=%b DOUT=%h, want SEL=%b DOUT=%h",
                             e.name, ADDR, SEL, DOUT, e.sel_e, e.dout_e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int kh, sh;
        logic [15:0] a;
        #1;
        step(1, 16'h0, 0, 16'h0, 0, "", 16'h0);
        step(1, 16'h0, 0, 16'h0, 0, "", 16'h0);

        // reset state
        chk("rst_kdata", BASE,          16'h000F);
        chk("rst_sdata", BASE + 16'd2,  16'h0000);
        chk("rst_kflag", BASE + 16'd4,  16'h0000);
        chk("rst_sflag", BASE + 16'd6,  16'h0000);
        chk("miss_0100", 16'h0100,      16'hDEAD);

        // KEY[0] press: visible exactly 6 edges after first sampling
        cur_key = 4'hE;
        run(5, BASE);
        chk("key0_edge5", BASE, 16'h000F);
        chk("key0_edge6", BASE, 16'h000E);
        chk("key0_flag",  BASE + 16'd4, 16'h0001);
        cur_key = 4'hF;
        run(8, BASE);

        // 3-cycle glitch filtered
        cur_key = 4'hE; run(3, BASE);
        cur_key = 4'hF; run(8, BASE);
        chk("glitch_kdata", BASE, 16'h000F);
        chk("glitch_kflag", BASE + 16'd4, 16'h0001);

        // second press -> overrun, then W1C
        cur_key = 4'hE; run(8, BASE);
        chk("overrun", BASE + 16'd4, 16'h0011);
        wr(BASE + 16'd4, 16'h0011);
        chk("kflag_clr", BASE + 16'd4, 16'h0000);
        cur_key = 4'hF; run(8, BASE);

        // SW[9] toggling
        cur_sw = 10'h200; run(10, BASE + 16'd2);
        chk("sw9_on", BASE + 16'd2, 16'h0200);
        cur_sw = 10'h000; run(10, BASE + 16'd2);
        chk("sw9_off",   BASE + 16'd2, 16'h0000);
        chk("sflag9",    BASE + 16'd6, 16'h0200);
        wr(BASE + 16'd6, 16'h0200);
        chk("sflag_clr", BASE + 16'd6, 16'h0000);

        // W1C of KFLAG[1] on the same edge as a new KEY[1] press
        cur_key = 4'hD; run(8, BASE);
        cur_key = 4'hF; run(8, BASE);
        chk("key1_flag", BASE + 16'd4, 16'h0002);
        cur_key = 4'hD; run(5, BASE);
        wr(BASE + 16'd4, 16'h0002);
        chk("set_wins", BASE + 16'd4, 16'h0002);
        wr(BASE, 16'h0000);
        chk("kdata_ro", BASE, 16'h000D);
        cur_key = 4'hF; run(8, BASE);
        wr(BASE + 16'd4, 16'h00FF);
        chk("kflag_all_clr", BASE + 16'd4, 16'h0000);

        // reset mid-count on KEY[2]
        cur_key = 4'hB; run(4, BASE);
        step(1, BASE, 0, 16'h0, 0, "", 16'h0);
        chk("rst_mid_kdata", BASE,          16'h000F);
        chk("rst_mid_kflag", BASE + 16'd4,  16'h0000);
        run(3, BASE);
        chk("key2_edge5", BASE, 16'h000F);
        chk("key2_edge6", BASE, 16'h000B);
        chk("key2_flag",  BASE + 16'd4, 16'h0004);
        cur_key = 4'hF; run(8, BASE);

        // randomized phase against the model
        kh = 0; sh = 0;
        for (int i = 0; i < 3000; i++) begin
            if (kh == 0) begin cur_key = 4'($urandom); kh = $urandom_range(1, 12); end
            else kh--;
            if (sh == 0) begin cur_sw = 10'($urandom); sh = $urandom_range(1, 12); end
            else sh--;
            if ($urandom_range(0, 9) == 0) a = 16'($urandom);
            else a = BASE + 16'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0)
                step(1, a, 0, 16'h0, 0, "", 16'h0);
            else
                step(0, a, ($urandom_range(0, 7) == 0), 16'($urandom), 0, "", 16'h0);
        end

        #20;
        if (n_err == 0 && n_checks > 0)
            $display("PASS");
        else
            $display("FAIL summary");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
